rst_seq_ctrl: RTL and testbench

Reset sequencer that sits on the source side of the per-domain reset synchronizers. It merges software and external reset requests and holds every domain reset for a guaranteed minimum width. It then releases the domain resets one at a time in a fixed order, waiting for each domain to acknowledge that it has left reset. Each `orst[i]` drives the asynchronous reset input of that domain's synchronizer.

---
 rtl/rst_seq_pkg.sv | 25 ++
 rtl/bit_sync2.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    S_ASSERT,
    S_HOLD,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;

  // One counter serves every phase, so it is sized for the longest one.
  function automatic int cnt_width(input int minw, input int gap, input int tout);
    int m;
    m = minw;
    if (gap > m) m = gap;
    if (tout > m) m = tout;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  function automatic bit params_ok(input int nrst, input int minw, input int gap, input int tout);
    return (nrst >= 1) && (nrst <= 16) && (minw >= 2) && (gap >= 1) && (tout > gap);
  endfunction

endpackage

// File: rtl/bit_sync2.sv
// Parameterizable-width two-flop synchronizer, async active-low reset to 0.
module bit_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         irst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] meta;
  (* ASYNC_REG = "TRUE" *) logic [W-1:0] sync;

  // NOTE: non-blocking assignments so the second flop takes the first flop's pre-edge value.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all domain resets for MINW cycles, then releases them in order.
// Define RST_SEQ_ACK_EN to wait for per-domain acknowledges (with timeout) between releases.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NRST = 4,
  parameter int MINW = 16,
  parameter int GAP  = 8,
  parameter int TOUT = 1024
) (
  input  logic            clk,
  input  logic            irst_n,
  input  logic            swrst,
  input  logic            extrst,
  input  logic [NRST-1:0] ack,
  output logic [NRST-1:0] orst,
  output logic            busy,
  output logic            done,
  output logic            tout_err
);

  localparam int CW = cnt_width(MINW, GAP, TOUT);
  localparam int IW = (NRST > 1) ? $clog2(NRST) : 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [IW-1:0] stg_t;
  localparam cnt_t HOLD_END = cnt_t'(MINW - 1);
  localparam cnt_t GAP_END  = cnt_t'(GAP);
  localparam stg_t LAST_STG = stg_t'(NRST - 1);

  if (!params_ok(NRST, MINW, GAP, TOUT)) begin : g_bad_params
    $error("rst_seq_ctrl: parameter out of range");
  end

  state_t state, state_nxt;
  cnt_t   cnt;
  stg_t   stg, rel_idx;
  logic   extrst_s, req, cnt_clr, rel, stg_exit, tout_hit, tout_set;

  bit_sync2 #(.W(1)) u_extrst_sync (.clk(clk), .irst_n(irst_n), .d(extrst), .q(extrst_s));

  assign req = swrst | extrst_s;

`ifdef RST_SEQ_ACK_EN
  localparam cnt_t TOUT_END = cnt_t'(TOUT - 1);
  logic [NRST-1:0] ack_s;

  bit_sync2 #(.W(NRST)) u_ack_sync (.clk(clk), .irst_n(irst_n), .d(ack), .q(ack_s));

  // Only the current stage's ack is looked at; a late or foreign ack cannot advance it.
  assign stg_exit = ack_s[stg] || (cnt == TOUT_END);
  assign tout_hit = !ack_s[stg] && (cnt == TOUT_END);
`else
  localparam cnt_t WAIT_END = cnt_t'(GAP - 1);
  logic unused_ack;

  assign unused_ack = ^ack;
  assign stg_exit   = (cnt == WAIT_END);
  assign tout_hit   = 1'b0;
`endif

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) state <= S_ASSERT;
    else         state <= state_nxt;
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    rel       = 1'b0;
    rel_idx   = stg;
    tout_set  = 1'b0;
    if (req) begin
      state_nxt = S_ASSERT;
      cnt_clr   = 1'b1;
    end else begin
      unique case (state)
        S_ASSERT: begin
          state_nxt = S_HOLD;
          cnt_clr   = 1'b1;
        end
        S_HOLD: if (cnt == HOLD_END) begin
          state_nxt = S_WAIT_ACK;
          cnt_clr   = 1'b1;
          rel       = 1'b1;
          rel_idx   = '0;
        end
        S_WAIT_ACK: if (stg_exit) begin
          state_nxt = (stg == LAST_STG) ? S_DONE : S_GAP;
          cnt_clr   = 1'b1;
          tout_set  = tout_hit;
        end
        S_GAP: if (cnt == GAP_END) begin
          state_nxt = S_WAIT_ACK;
          cnt_clr   = 1'b1;
          rel       = 1'b1;
          rel_idx   = stg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Releases are registered so each orst bit is a clean flop output into the domain synchronizer.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      cnt      <= '0;
      stg      <= '0;
      orst     <= '1;
      tout_err <= 1'b0;
    end else begin
      if (cnt_clr)         cnt <= '0;
      else if (cnt != '1)  cnt <= cnt + 1'b1;
      if (state == S_ASSERT) orst <= '1;
      else if (rel)          orst[rel_idx] <= 1'b0;
      if (rel)      stg      <= rel_idx;
      if (tout_set) tout_err <= 1'b1;
    end
  end

  always_comb begin
    busy = (state != S_DONE);
    done = (state == S_DONE);
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: expected output changes come from a timeline model.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  localparam int NRST = 4;
  localparam int MINW = 16;
  localparam int GAP  = 8;
  localparam int TOUT = 1024;
`ifdef RST_SEQ_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            irst_n, swrst, extrst;
  logic [NRST-1:0] ack, orst;
  logic            busy, done, tout_err;

  rst_seq_ctrl #(.NRST(NRST), .MINW(MINW), .GAP(GAP), .TOUT(TOUT)) dut (
    .clk(clk), .irst_n(irst_n), .swrst(swrst), .extrst(extrst), .ack(ack),
    .orst(orst), .busy(busy), .done(done), .tout_err(tout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              edge_n;
    logic [NRST-1:0] orst;
    logic            done;
    logic            te;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ack_at[NRST];
  bit  te_m = 1'b0;

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s %s", name, detail);
    end
  endtask

  // Monitor: every change of the observable outputs must match the next expected event.
  bit              mon_en = 1'b0;
  logic [NRST-1:0] p_orst;
  logic            p_done, p_te;
  int              ev_n = 0;

  always @(negedge clk) begin
    if (mon_en && (orst !== p_orst || done !== p_done || tout_err !== p_te)) begin
      ev_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_change", 1'b0, $sformatf("edge=%0d orst=%h done=%b tout_err=%b, none expected",
              cyc, orst, done, tout_err));
      end else begin
        e = exp_q.pop_front();
        check($sformatf("ev%0d", ev_n),
              e.edge_n == cyc && e.orst === orst && e.done === done && e.te === tout_err && busy === !e.done,
              $sformatf("got edge=%0d orst=%h done=%b busy=%b tout_err=%b want edge=%0d orst=%h done=%b busy=%b tout_err=%b",
                        cyc, orst, done, busy, tout_err, e.edge_n, e.orst, e.done, !e.done, e.te));
      end
      ev_n++;
      p_orst = orst;
      p_done = done;
      p_te   = tout_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NRST; i++)
      if (ack_at[i] == cyc) ack[i] = 1'b1;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic clear_acks();
    ack = '0;
    foreach (ack_at[i]) ack_at[i] = -1;
  endtask

  task automatic rand_d(output int d[NRST]);
    foreach (d[i]) d[i] = int'($urandom_range(0, 10));
  endtask

  // Timeline of one sequence that leaves ASSERT at edge q. Domain i raises ack d[i] cycles
  // after its release (d<0: never). Stops right after releasing stage nst-1.
  task automatic push_seq(input int q, input int d[NRST], input int nst,
                          output int r_last, output int end_edge);
    logic [NRST-1:0] v;
    int r, l;
    bit te_old;
    v = '1;
    r = q + MINW;
    r_last = r;
    end_edge = r;
    for (int i = 0; i < nst; i++) begin
      te_old = te_m;
      v[i] = 1'b0;
      exp_q.push_back('{r, v, 1'b0, te_m});
      ack_at[i] = (d[i] < 0) ? -1 : r + d[i];
      r_last = r;
      end_edge = r;
      if (nst < NRST && i == nst - 1) break;
      if (!ACK_EN)                          l = r + GAP;
      else if (d[i] >= 0 && d[i] + 3 <= TOUT) l = r + d[i] + 3;
      else begin
        l = r + TOUT;
        te_m = 1'b1;
      end
      if (i == NRST - 1)      exp_q.push_back('{l, v, 1'b1, te_m});
      else if (te_m != te_old) exp_q.push_back('{l, v, 1'b0, te_m});
      end_edge = l;
      r = l + GAP + 1;
    end
  endtask

  // One-cycle swrst from DONE: done drops on the next edge, orst is all ones the edge after.
  task automatic sw_pulse(output int q);
    int t;
    t = cyc;
    clear_acks();
    swrst = 1'b1;
    exp_q.push_back('{t + 1, {NRST{1'b0}}, 1'b0, te_m});
    exp_q.push_back('{t + 2, {NRST{1'b1}}, 1'b0, te_m});
    tick();
    swrst = 1'b0;
    q = t + 2;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_orst"}, orst === {NRST{1'b1}}, $sformatf("got %h want %h", orst, {NRST{1'b1}}));
    check({tag, "_busy"}, busy === 1'b1, $sformatf("got %b want 1", busy));
    check({tag, "_done"}, done === 1'b0, $sformatf("got %b want 0", done));
    check({tag, "_tout_err"}, tout_err === 1'b0, $sformatf("got %b want 0", tout_err));
  endtask

  initial begin
    int q, rl, de, x, l0, t;
    int dv[NRST];
    irst_n = 1'b1;
    swrst  = 1'b0;
    extrst = 1'b0;
    clear_acks();
    #2 irst_n = 1'b0;
    #1 check_reset_vals("por_async");
    repeat (3) tick();
    check_reset_vals("por_clocked");

    // Power-up with every domain acknowledging 5 cycles after its release.
    p_orst = '1;
    p_done = 1'b0;
    p_te   = 1'b0;
    mon_en = 1'b1;
    irst_n = 1'b1;
    foreach (dv[i]) dv[i] = 5;
    push_seq(cyc + 1, dv, NRST, rl, de);
    run_to(de + 4);

    // Software reset from DONE, random ack delays.
    sw_pulse(q);
    rand_d(dv);
    push_seq(q, dv, NRST, rl, de);
    run_to(de + 4);

    // External reset held 40 cycles while holding: the hold restarts from its release.
    sw_pulse(q);
    run_to(q + 4);
    extrst = 1'b1;
    run_to(cyc + 40);
    extrst = 1'b0;
    rand_d(dv);
    push_seq(cyc + 3, dv, NRST, rl, de);
    run_to(de + 4);

    // Domain 2 never acknowledges.
    sw_pulse(q);
    rand_d(dv);
    dv[2] = -1;
    push_seq(q, dv, NRST, rl, de);
    run_to(de + 4);

    // swrst lands on the same edge that first sees ack_s[1].
    sw_pulse(q);
    rand_d(dv);
    dv[1] = int'($urandom_range(0, 4));
    push_seq(q, dv, 2, rl, de);
    x = rl + dv[1] + 3;
    run_to(x - 1);
    swrst = 1'b1;
    clear_acks();
    tick();
    swrst = 1'b0;
    exp_q.push_back('{x + 1, {NRST{1'b1}}, 1'b0, te_m});
    rand_d(dv);
    push_seq(x + 1, dv, NRST, rl, de);
    run_to(de + 4);

    // irst_n pulse in the gap after stage 0.
    sw_pulse(q);
    rand_d(dv);
    push_seq(q, dv, 1, rl, de);
    l0 = ACK_EN ? rl + dv[0] + 3 : rl + GAP;
    run_to(l0 + 3);
    t = cyc;
    te_m = 1'b0;
    exp_q.push_back('{t, {NRST{1'b1}}, 1'b0, 1'b0});
    irst_n = 1'b0;
    #1 check_reset_vals("mid_gap_async");
    clear_acks();
    #1 irst_n = 1'b1;
    rand_d(dv);
    push_seq(t + 1, dv, NRST, rl, de);
    run_to(de + 4);

    check("events_drained", exp_q.size() == 0, $sformatf("got %0d pending want 0", exp_q.size()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
